// File: rtl/altpll_status_model_if.sv
// rtl/altpll_status_model_if.sv - switchover/lock status link between altpll_ctrl and the PLL model
`timescale 1ns/1ps

interface altpll_status_model_if;
    logic clkswitch;
    logic fault_noswitch;
    logic fault_nolock;
    logic activeclk;
    logic locked;
    logic switch_busy;

    // controller side: issues switch requests and fault injections, observes status
    modport master (
        output clkswitch,
        output fault_noswitch,
        output fault_nolock,
        input  activeclk,
        input  locked,
        input  switch_busy
    );

    // PLL side: consumes requests, reports status
    modport slave (
        input  clkswitch,
        input  fault_noswitch,
        input  fault_nolock,
        output activeclk,
        output locked,
        output switch_busy
    );
endinterface

// File: rtl/altpll_status_model.sv
// rtl/altpll_status_model.sv - ALTPLL switchover/lock responder with fault injection
`timescale 1ns/1ps

module altpll_status_model #(
    parameter int   SWITCH_LAT     = 2,
    parameter int   LOCK_LAT       = 4,
    parameter logic INIT_ACTIVECLK = 1'b0
) (
    input  logic                  clk,
    input  logic                  areset,
    altpll_status_model_if.slave  bus
);

    localparam int SW_W = $clog2((SWITCH_LAT < 2) ? 2 : SWITCH_LAT);
    localparam int LK_W = $clog2((LOCK_LAT < 2) ? 2 : LOCK_LAT);
    localparam logic [SW_W-1:0] SW_LOAD = SW_W'(SWITCH_LAT - 1);
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_LAT - 1);

    generate
        if (SWITCH_LAT < 1 || LOCK_LAT < 1) begin : g_bad_param
            $error("altpll_status_model: SWITCH_LAT and LOCK_LAT must be >= 1");
        end
    endgenerate

    // Idle encodes as zero so the switch sequencer's power-up (all flops clear)
    // is the idle state; it has no reset because areset must never disturb it.
    typedef enum logic {SW_IDLE = 1'b0, SW_WAIT = 1'b1} sw_state_t;
    typedef enum logic [1:0] {L_RST = 2'd0, L_ACQ = 2'd1, L_LOCKED = 2'd2} lk_state_t;

    sw_state_t       sw_state;
    logic [SW_W-1:0] sw_cnt;
    logic            clkswitch_q;
    logic            active_tog;     // parity of completed switchovers
    logic            switch_busy_r;

    lk_state_t       lk_state;
    logic [LK_W-1:0] lk_cnt;
    logic            locked_r;

    logic            sw_evt;

    assign sw_evt = bus.clkswitch & ~clkswitch_q & ~bus.fault_noswitch;

    // Switch sequencer: accept one rising-edge request, toggle the reference SWITCH_LAT edges later
    always_ff @(posedge clk) begin
        clkswitch_q <= bus.clkswitch;
        case (sw_state)
            SW_IDLE: begin
                if (sw_evt) begin
                    sw_state      <= SW_WAIT;
                    sw_cnt        <= SW_LOAD;
                    switch_busy_r <= 1'b1;
                end
            end
            SW_WAIT: begin
                if (sw_cnt == '0) begin
                    active_tog    <= ~active_tog;
                    sw_state      <= SW_IDLE;
                    switch_busy_r <= 1'b0;
                end else begin
                    sw_cnt <= sw_cnt - SW_W'(1);
                end
            end
            default: begin
                sw_state      <= SW_IDLE;
                switch_busy_r <= 1'b0;
            end
        endcase
    end

    // Lock FSM: needs LOCK_LAT consecutive clean edges; any switch activity or fault restarts acquisition
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            lk_state <= L_RST;
            lk_cnt   <= '0;
            locked_r <= 1'b0;
        end else begin
            case (lk_state)
                L_RST: begin
                    lk_state <= L_ACQ;
                    lk_cnt   <= '0;
                end
                L_ACQ: begin
                    if (switch_busy_r || sw_evt || bus.fault_nolock) begin
                        lk_cnt <= '0;
                    end else if (lk_cnt == LK_LAST) begin
                        lk_state <= L_LOCKED;
                        locked_r <= 1'b1;
                    end else begin
                        lk_cnt <= lk_cnt + LK_W'(1);
                    end
                end
                L_LOCKED: begin
                    if (sw_evt || bus.fault_nolock) begin
                        lk_state <= L_ACQ;
                        lk_cnt   <= '0;
                        locked_r <= 1'b0;
                    end
                end
                default: begin
                    lk_state <= L_RST;
                    lk_cnt   <= '0;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.activeclk   = active_tog ^ INIT_ACTIVECLK;
    assign bus.locked      = locked_r;
    assign bus.switch_busy = switch_busy_r;

endmodule
